xz_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the x/z-driven Moore FSM.
- Takes two asynchronous raw control inputs, synchronises each one, and debounces them as a pair.
- Presents a glitch-free, atomically updated {x,z} pair plus a one-cycle change strobe.
- Because both outputs only ever change on the same clock edge, the downstream FSM never sees a transient mixed pair, such as 10 while moving 00->11.

---
 rtl/xz_pkg.sv | 17 +
 rtl/sync_chain.sv | 27 ++
 rtl/xz_debounce.sv | 174 +++++++++++++++++
 tb/tb_xz_debounce.sv | 135 +++++++++++++
 4 files changed

// File: rtl/xz_pkg.sv
// Shared types for the x/z input conditioning stage.
//   state_e  : debouncer state (stable / settling / post-commit lockout)
//   pair_t   : {x, z} pair, x in bit 1, z in bit 0
//   XZ_RESET : pair value loaded on reset
package xz_pkg;

  typedef enum logic [1:0] {
    StStable   = 2'd0,
    StSettling = 2'd1,
    StLockout  = 2'd2
  } state_e;

  typedef logic [1:0] pair_t;

  localparam pair_t XZ_RESET = 2'b00;

endpackage

// File: rtl/sync_chain.sv
// One-bit multi-flop synchroniser for an asynchronous input.
//   clk_i : sampling clock
//   rst_i : synchronous, active-high reset; clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output (last stage)
module sync_chain #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/xz_debounce.sv
// Synchronises and pair-debounces the raw x/z controls so the downstream FSM only
// ever sees {x, z} change atomically, with a one-cycle strobe on every commit.
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset
//   x_raw : asynchronous raw x
//   z_raw : asynchronous raw z
//   x, z  : debounced pair, registered
//   chg   : one-cycle pulse in the cycle after a new pair is committed
//   busy  : candidate settling or post-commit lockout in progress
// Optional: define XZ_DEBOUNCE_LOCKOUT_EN to ignore the inputs for LOCKOUT_CYCLES
// edges after each commit.
module xz_debounce
  import xz_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned LOCKOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  input  logic z_raw,
  output logic x,
  output logic z,
  output logic chg,
  output logic busy
);

  localparam int unsigned   CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES);

  logic            x_sync, z_sync;
  pair_t           s;
  state_e          state_q, state_d;
  pair_t           out_q, out_d;
  pair_t           cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            chg_q, chg_d;
  logic            busy_q, busy_d;
  logic            commit;

  sync_chain #(
    .Stages(SYNC_STAGES)
  ) u_sync_x (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (x_raw),
    .q_o  (x_sync)
  );

  sync_chain #(
    .Stages(SYNC_STAGES)
  ) u_sync_z (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (z_raw),
    .q_o  (z_sync)
  );

  assign s = {x_sync, z_sync};

`ifdef XZ_DEBOUNCE_LOCKOUT_EN
  localparam int unsigned   LkW    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LkW-1:0] LkLast = LkW'(LOCKOUT_CYCLES - 1);

  logic [LkW-1:0] lk_q, lk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_q <= '0;
    end else begin
      lk_q <= lk_d;
    end
  end
`else
  logic [31:0] unused_lockout_cycles;
  assign unused_lockout_cycles = LOCKOUT_CYCLES;
`endif

  // State register: every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStable;
      out_q   <= XZ_RESET;
      cand_q  <= XZ_RESET;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
`ifdef XZ_DEBOUNCE_LOCKOUT_EN
    lk_d    = lk_q;
`endif
    unique case (state_q)
      StStable: begin
        cnt_d = '0;
        if (s != out_q) begin
          cand_d = s;
          // A single matching sample is already enough when DEB_CYCLES is 1.
          if (DebLast == CntW'(1)) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StSettling;
          end
        end
      end
      StSettling: begin
        if (s == out_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (s == cand_q) begin
          if (cnt_q + CntW'(1) == DebLast) begin
            commit = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cand_d = s;
          cnt_d  = CntW'(1);
        end
      end
`ifdef XZ_DEBOUNCE_LOCKOUT_EN
      StLockout: begin
        if (lk_q == LkLast) begin
          state_d = StStable;
        end else begin
          lk_d = lk_q + LkW'(1);
        end
      end
`endif
      default: state_d = StStable;
    endcase
    if (commit) begin
`ifdef XZ_DEBOUNCE_LOCKOUT_EN
      state_d = StLockout;
      lk_d    = '0;
`else
      state_d = StStable;
`endif
    end
  end

  // Output logic: x and z load together so no mixed pair is ever visible.
  always_comb begin
    out_d  = out_q;
    if (commit) begin
      out_d = cand_d;
    end
    chg_d  = commit;
    busy_d = (state_d == StSettling) || (state_d == StLockout);
  end

  assign x    = out_q[1];
  assign z    = out_q[0];
  assign chg  = chg_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_xz_debounce.sv
// Directed bench for xz_debounce with SYNC_STAGES=2, DEB_CYCLES=4, LOCKOUT_CYCLES=8.
// Edge e counts rising edges after the stimulus is applied; outputs are sampled 1 ns
// after each edge and compared as {x, z, chg, busy}.
module tb_xz_debounce;

`ifdef XZ_DEBOUNCE_LOCKOUT_EN
  localparam int Lk = 8;
`else
  localparam int Lk = 0;
`endif

  logic clk;
  logic rst;
  logic x_raw, z_raw;
  logic x, z, chg, busy;

  int n_run;
  int n_fail;

  xz_debounce #(
    .SYNC_STAGES   (2),
    .DEB_CYCLES    (4),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .x_raw(x_raw),
    .z_raw(z_raw),
    .x    (x),
    .z    (z),
    .chg  (chg),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got xz/chg/busy=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] raw);
    rst            = 1'b1;
    {x_raw, z_raw} = raw;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("reset c%0d", i), {x, z, chg, busy}, 4'b0000);
    end
    rst = 1'b0;
  endtask

  // Apply raw_a before edge 1, switch to raw_b after edge sw (0 = never); expect a
  // single commit of post at edge ce (0 = none) and busy over [bf, bt).
  task automatic run(input string tag, input int n, input logic [1:0] raw_a, input int sw,
                     input logic [1:0] raw_b, input int ce, input logic [1:0] post,
                     input int bf, input int bt);
    logic [1:0] xz;
    {x_raw, z_raw} = raw_a;
    for (int e = 1; e <= n; e++) begin
      tick();
      xz = (ce > 0 && e >= ce) ? post : 2'b00;
      check_eq($sformatf("%s e%0d", tag, e), {x, z, chg, busy},
               {xz, (e == ce), (e >= bf && e < bt)});
      if (e == sw) {x_raw, z_raw} = raw_b;
    end
  endtask

  initial begin
    int         c2;
    int         b2;
    logic [1:0] xz;
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    x_raw  = 1'b0;
    z_raw  = 1'b0;

    // Reset with raw=11 held; first commit 6 edges after release.
    do_reset(2'b11);
    run("s1", 8, 2'b11, 0, 2'b11, 6, 2'b11, 3, 6 + Lk);

    // Clean 00->01 change.
    do_reset(2'b00);
    run("s2", 8, 2'b01, 0, 2'b01, 6, 2'b01, 3, 6 + Lk);

    // Three-cycle glitch to 10 is rejected.
    do_reset(2'b00);
    run("s3", 9, 2'b10, 3, 2'b00, 0, 2'b00, 3, 6);

    // Candidate switches 10 -> 11; out goes straight 00 -> 11.
    do_reset(2'b00);
    run("s4", 10, 2'b10, 2, 2'b11, 8, 2'b11, 3, 8 + Lk);

    // Reset when count reaches 3 discards the candidate, then settling restarts.
    do_reset(2'b00);
    run("s5a", 5, 2'b11, 0, 2'b11, 0, 2'b00, 3, 100);
    rst = 1'b1;
    tick();
    check_eq("s5 rst", {x, z, chg, busy}, 4'b0000);
    rst = 1'b0;
    run("s5b", 8, 2'b11, 0, 2'b11, 6, 2'b11, 3, 6 + Lk);

    // Commit of 11, raw drops back to 00 immediately after.
    do_reset(2'b00);
`ifdef XZ_DEBOUNCE_LOCKOUT_EN
    c2 = 18;
    b2 = 15;
`else
    c2 = 12;
    b2 = 9;
`endif
    {x_raw, z_raw} = 2'b11;
    for (int e = 1; e <= c2 + 1; e++) begin
      tick();
      xz = (e >= 6 && e < c2) ? 2'b11 : 2'b00;
      check_eq($sformatf("s6 e%0d", e), {x, z, chg, busy},
               {xz, (e == 6 || e == c2),
                ((e >= 3 && e < 6 + Lk) || (e >= b2 && e < c2 + Lk))});
      if (e == 6) {x_raw, z_raw} = 2'b00;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
